hd44780_init_sequencer: RTL and testbench
=========================================

// Module: hd44780_init_sequencer
// PURPOSE
//  Power-on initialiser for an HD44780 LCD in 4-bit mode. Initiator side of the state-timer
//  handshake (start strobe + load value out, busy back) and of the nybble-sender handshake.
//  Runs a fixed 9-step command script after reset, then raises done so the byte writer can take
//  over the LCD bus. Sits between the top-level LCD controller and the state timer / nybble sender.
// PARAMETERS
//  STATE_TIMER_BITS  `H4_TIMER_BITS   width of tmr_dat; must match the state timer
// PORTS
//  CLK_I         in   1                 system clock; the block's only clock
//  RST_I         in   1                 reset: asynchronous, active-low
//  tmr_start     out  1                 1-cycle pulse: state timer loads tmr_dat
//  tmr_dat       out  STATE_TIMER_BITS  delay in clock ticks; valid while tmr_start=1
//  tmr_busy      in   1                 state timer busy (registered, rises 1 cycle after tmr_start)
//  nyb_start     out  1                 1-cycle pulse: nybble sender latches nyb_dat/nyb_rs
//  nyb_dat       out  4                 nybble to send; valid while nyb_start=1
//  nyb_rs        out  1                 LCD RS; always 0 (commands only)
//  nyb_busy      in   1                 nybble sender busy (rises 1 cycle after nyb_start)
//  busy          out  1                 1 from reset release until script done
//  done          out  1                 1 after last step's delay expires; sticky until reset
// BEHAVIOUR
//  - While RST_I=0: state=PWR; tmr_start=nyb_start=0, tmr_dat=0, nyb_dat=0, nyb_rs=0, busy=1,
//    done=0, step=0. Reset asserted mid-script aborts immediately; the script restarts from PWR.
//  - All outputs registered. Delay constants: D53=`H4_DELAY_53US, D100=`H4_DELAY_100US,
//    D4P1=`H4_DELAY_4P1MS, D3=`H4_DELAY_3MS, DPWR=`H4_DELAY_100MS; zero-extend/truncate to width.
//  - Handshake rule (both peers): pulse start for exactly 1 cycle, spend 1 ARM cycle (busy not
//    yet valid), then WAIT until busy=0. Busy already 0 on the first WAIT cycle -> advance next cycle.
//  - States: PWR -> PWR_ARM -> PWR_WAIT -> LOAD -> NHI -> NHI_ARM -> NHI_WAIT -> [byte step:
//    NLO -> NLO_ARM -> NLO_WAIT] -> DLY -> DLY_ARM -> DLY_WAIT -> LOAD (step+1) | DONE.
//    PWR pulses tmr_start with DPWR. NHI sends data[7:4]; NLO sends data[3:0]; nybble steps skip
//    NLO*. DLY pulses tmr_start with the step's delay. DONE: busy=0, done=1, no further strobes.
//  - Script (kind, data, delay): 0 NYB 0x3 D4P1; 1 NYB 0x3 D100; 2 NYB 0x3 D100; 3 NYB 0x2 D53;
//    4 BYTE 0x28 D53; 5 BYTE 0x08 D53; 6 BYTE 0x01 D3; 7 BYTE 0x06 D53; 8 BYTE 0x0C D53.
//    Nybble steps store the nybble in data[7:4].
//  - tmr_start and nyb_start are never high in the same cycle; no strobe is issued while the
//    corresponding busy input is 1. step is 4 bits; after step 8, DLY_WAIT exit goes to DONE (no wrap).
//  - A busy input held 1 indefinitely stalls in that WAIT state (no timeout).
// CONFIGURATION
//  `H4_FAST_POWERUP_EN defined: PWR loads D100 instead of DPWR (sim/bring-up, shortens run).
//  Undefined: PWR loads DPWR. No other behaviour changes.
// STRUCTURE
//  Shared package/include (hd44780 config .inc): delay defines above, step-kind encoding
//  (H4_STEP_NYB=0, H4_STEP_BYTE=1), delay-select encoding (2 bits: 0=D53,1=D100,2=D4P1,3=D3),
//  H4_INIT_STEPS=9. Sub-module: hd44780_init_rom - combinational step -> {kind, data[7:0],
//  dsel[1:0]} table. Sequencer FSM, step counter and output regs stay in this module.
// TESTING (sim config delays; behavioural timer and nybble-sender models with 1-cycle busy lag)
//  1 Reset release -> tmr_start 1 cycle with tmr_dat=DPWR; then nybbles 3,3,3,2 then 2,8,0,8,0,1,
//    0,6,0,C in order, nyb_rs=0 always, done=1 and busy=0 after the last D53 expires.
//  2 Each nyb_start/tmr_start pulse exactly 1 cycle; never overlapping; none while peer busy=1.
//  3 Step 6 (0x01): tmr_dat=D3 after low nybble; step 0: tmr_dat=D4P1; step 3: tmr_dat=D53.
//  4 Nybble model holds busy 20 extra cycles -> sequencer waits, next strobe 2 cycles after busy falls.
//  5 RST_I low during step 5 wait -> outputs at reset values immediately; release -> restarts at PWR.
//  6 `H4_FAST_POWERUP_EN build -> first tmr_dat=D100; rest of trace identical to test 1.

Source files
------------

// File: rtl/hd44780_init_sequencer_pkg.sv
// Shared configuration for the HD44780 4-bit power-on initialiser.
// Delay macros default to a short simulation scale. Override them with
// +define for a real system clock, and widen H4_TIMER_BITS to match.
// Optional build macro used by the sequencer: H4_FAST_POWERUP_EN.
`ifndef H4_TIMER_BITS
`define H4_TIMER_BITS 16
`endif
`ifndef H4_DELAY_53US
`define H4_DELAY_53US 6
`endif
`ifndef H4_DELAY_100US
`define H4_DELAY_100US 9
`endif
`ifndef H4_DELAY_4P1MS
`define H4_DELAY_4P1MS 25
`endif
`ifndef H4_DELAY_3MS
`define H4_DELAY_3MS 18
`endif
`ifndef H4_DELAY_100MS
`define H4_DELAY_100MS 40
`endif

package hd44780_init_sequencer_pkg;

  // Sequencer states; dbg_state exposes this encoding.
  typedef enum logic [3:0] {
    ST_PWR      = 4'd0,
    ST_PWR_ARM  = 4'd1,
    ST_PWR_WAIT = 4'd2,
    ST_LOAD     = 4'd3,
    ST_NHI      = 4'd4,
    ST_NHI_ARM  = 4'd5,
    ST_NHI_WAIT = 4'd6,
    ST_NLO      = 4'd7,
    ST_NLO_ARM  = 4'd8,
    ST_NLO_WAIT = 4'd9,
    ST_DLY      = 4'd10,
    ST_DLY_ARM  = 4'd11,
    ST_DLY_WAIT = 4'd12,
    ST_DONE     = 4'd13
  } h4_state_e;

  // Step kind: a lone high nybble or a full byte (high then low nybble).
  localparam logic H4_STEP_NYB  = 1'b0;
  localparam logic H4_STEP_BYTE = 1'b1;

  // Post-step delay selector.
  typedef enum logic [1:0] {
    H4_DSEL_53  = 2'd0,
    H4_DSEL_100 = 2'd1,
    H4_DSEL_4P1 = 2'd2,
    H4_DSEL_3   = 2'd3
  } h4_dsel_e;

  localparam int H4_INIT_STEPS = 9;

  localparam int H4_D53   = `H4_DELAY_53US;
  localparam int H4_D100  = `H4_DELAY_100US;
  localparam int H4_D4P1  = `H4_DELAY_4P1MS;
  localparam int H4_D3    = `H4_DELAY_3MS;
  localparam int H4_DPWR  = `H4_DELAY_100MS;

  // One script entry. Nybble steps keep their nybble in data[7:4].
  typedef struct packed {
    logic       kind;
    logic [7:0] data;
    h4_dsel_e   dsel;
  } h4_step_t;

endpackage

// File: rtl/hd44780_init_rom.sv
// Fixed 9-step HD44780 4-bit initialisation script, indexed by step number.
module hd44780_init_rom
  import hd44780_init_sequencer_pkg::*;
(
  input  logic [3:0] step,
  output h4_step_t   entry
);

  // Combinational lookup; out-of-range steps return a harmless nybble 0.
  always_comb begin
    entry = '{kind: H4_STEP_NYB, data: 8'h00, dsel: H4_DSEL_53};
    case (step)
      4'd0: entry = '{kind: H4_STEP_NYB,  data: 8'h30, dsel: H4_DSEL_4P1};
      4'd1: entry = '{kind: H4_STEP_NYB,  data: 8'h30, dsel: H4_DSEL_100};
      4'd2: entry = '{kind: H4_STEP_NYB,  data: 8'h30, dsel: H4_DSEL_100};
      4'd3: entry = '{kind: H4_STEP_NYB,  data: 8'h20, dsel: H4_DSEL_53};
      4'd4: entry = '{kind: H4_STEP_BYTE, data: 8'h28, dsel: H4_DSEL_53};
      4'd5: entry = '{kind: H4_STEP_BYTE, data: 8'h08, dsel: H4_DSEL_53};
      4'd6: entry = '{kind: H4_STEP_BYTE, data: 8'h01, dsel: H4_DSEL_3};
      4'd7: entry = '{kind: H4_STEP_BYTE, data: 8'h06, dsel: H4_DSEL_53};
      4'd8: entry = '{kind: H4_STEP_BYTE, data: 8'h0C, dsel: H4_DSEL_53};
      default: ;
    endcase
  end

endmodule

// File: rtl/hd44780_init_sequencer.sv
// HD44780 4-bit power-on initialiser: waits the power-up delay, walks the
// init script through the nybble sender and state timer, then raises done.
// Build option: H4_FAST_POWERUP_EN shortens the power-up delay to D100.
//
// Handshake (timer and nybble sender alike): the issue state registers a
// 1-cycle start pulse with its data; the pulse is visible during the ARM
// cycle, where the peer's busy is not yet meaningful. The WAIT state then
// holds until the peer's busy is 0 and advances on the following edge.
module hd44780_init_sequencer
  import hd44780_init_sequencer_pkg::*;
#(
  parameter int STATE_TIMER_BITS = `H4_TIMER_BITS
) (
  input  logic                        CLK_I,
  input  logic                        RST_I,
  output logic                        tmr_start,
  output logic [STATE_TIMER_BITS-1:0] tmr_dat,
  input  logic                        tmr_busy,
  output logic                        nyb_start,
  output logic [3:0]                  nyb_dat,
  output logic                        nyb_rs,
  input  logic                        nyb_busy,
  output logic                        busy,
  output logic                        done,
  output h4_state_e                   dbg_state,
  output logic [3:0]                  dbg_step
);

  localparam logic [STATE_TIMER_BITS-1:0] D53_W  = STATE_TIMER_BITS'(H4_D53);
  localparam logic [STATE_TIMER_BITS-1:0] D100_W = STATE_TIMER_BITS'(H4_D100);
  localparam logic [STATE_TIMER_BITS-1:0] D4P1_W = STATE_TIMER_BITS'(H4_D4P1);
  localparam logic [STATE_TIMER_BITS-1:0] D3_W   = STATE_TIMER_BITS'(H4_D3);
`ifdef H4_FAST_POWERUP_EN
  localparam logic [STATE_TIMER_BITS-1:0] PWR_W  = D100_W;
`else
  localparam logic [STATE_TIMER_BITS-1:0] PWR_W  = STATE_TIMER_BITS'(H4_DPWR);
`endif
  localparam logic [3:0] LAST_STEP = 4'(H4_INIT_STEPS - 1);

  h4_state_e                   state, state_d;
  logic [3:0]                  step, step_d;
  h4_step_t                    rom_entry;
  logic                        tmr_start_d, nyb_start_d, busy_d, done_d;
  logic [STATE_TIMER_BITS-1:0] tmr_dat_d;
  logic [3:0]                  nyb_dat_d;

  function automatic logic [STATE_TIMER_BITS-1:0] dsel_delay(input h4_dsel_e dsel);
    case (dsel)
      H4_DSEL_53:  return D53_W;
      H4_DSEL_100: return D100_W;
      H4_DSEL_4P1: return D4P1_W;
      default:     return D3_W;
    endcase
  endfunction

  hd44780_init_rom u_rom (
    .step  (step),
    .entry (rom_entry)
  );

  // State and step registers; reset restarts the script from power-up.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state <= ST_PWR;
      step  <= 4'd0;
    end else begin
      state <= state_d;
      step  <= step_d;
    end
  end

  // Next-state: strobe -> arm -> wait-for-idle for each peer transaction.
  always_comb begin
    state_d = state;
    step_d  = step;
    case (state)
      ST_PWR:      state_d = ST_PWR_ARM;
      ST_PWR_ARM:  state_d = ST_PWR_WAIT;
      ST_PWR_WAIT: if (!tmr_busy) state_d = ST_LOAD;
      ST_LOAD:     state_d = ST_NHI;
      ST_NHI:      state_d = ST_NHI_ARM;
      ST_NHI_ARM:  state_d = ST_NHI_WAIT;
      ST_NHI_WAIT: begin
        if (!nyb_busy) state_d = (rom_entry.kind == H4_STEP_BYTE) ? ST_NLO : ST_DLY;
      end
      ST_NLO:      state_d = ST_NLO_ARM;
      ST_NLO_ARM:  state_d = ST_NLO_WAIT;
      ST_NLO_WAIT: if (!nyb_busy) state_d = ST_DLY;
      ST_DLY:      state_d = ST_DLY_ARM;
      ST_DLY_ARM:  state_d = ST_DLY_WAIT;
      ST_DLY_WAIT: begin
        if (!tmr_busy) begin
          if (step == LAST_STEP) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
            step_d  = step + 4'd1;
          end
        end
      end
      ST_DONE:     state_d = ST_DONE;
      default:     state_d = ST_PWR;
    endcase
  end

  // Output decode: values the output registers take on the next edge.
  always_comb begin
    tmr_start_d = 1'b0;
    tmr_dat_d   = '0;
    nyb_start_d = 1'b0;
    nyb_dat_d   = 4'h0;
    case (state)
      ST_PWR: begin
        tmr_start_d = 1'b1;
        tmr_dat_d   = PWR_W;
      end
      ST_NHI: begin
        nyb_start_d = 1'b1;
        nyb_dat_d   = rom_entry.data[7:4];
      end
      ST_NLO: begin
        nyb_start_d = 1'b1;
        nyb_dat_d   = rom_entry.data[3:0];
      end
      ST_DLY: begin
        tmr_start_d = 1'b1;
        tmr_dat_d   = dsel_delay(rom_entry.dsel);
      end
      default: ;
    endcase
    busy_d = (state_d != ST_DONE);
    done_d = (state_d == ST_DONE);
  end

  // Output registers; busy is high from reset until the script completes.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      tmr_start <= 1'b0;
      tmr_dat   <= '0;
      nyb_start <= 1'b0;
      nyb_dat   <= 4'h0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else begin
      tmr_start <= tmr_start_d;
      tmr_dat   <= tmr_dat_d;
      nyb_start <= nyb_start_d;
      nyb_dat   <= nyb_dat_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // The initialiser only ever issues commands.
  assign nyb_rs    = 1'b0;
  assign dbg_state = state;
  assign dbg_step  = step;

endmodule

// File: tb/tb_hd44780_init_sequencer.sv
// Bench for hd44780_init_sequencer: behavioural state-timer and nybble-sender
// peers, an expected-event queue built from the init script, a negedge monitor.
module tb_hd44780_init_sequencer;
  import hd44780_init_sequencer_pkg::*;

  // Sim-config delays in clock ticks.
  localparam logic [15:0] D53  = 16'd6;
  localparam logic [15:0] D100 = 16'd9;
  localparam logic [15:0] D4P1 = 16'd25;
  localparam logic [15:0] D3   = 16'd18;
`ifdef H4_FAST_POWERUP_EN
  localparam logic [15:0] PWR_EXP = D100;
`else
  localparam logic [15:0] PWR_EXP = 16'd40;
`endif

  // Init script: data (nybble steps in [7:4]), byte flag, post delay.
  logic [7:0]  scr_data [9] = '{8'h30, 8'h30, 8'h30, 8'h20, 8'h28, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic        scr_byte [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [15:0] scr_dly  [9] = '{D4P1, D100, D100, D53, D53, D53, D3, D53, D53};

  logic        clk, rst_n;
  logic        tmr_start, tmr_busy, nyb_start, nyb_rs, nyb_busy, busy, done;
  logic [15:0] tmr_dat;
  logic [3:0]  nyb_dat, dbg_step;
  h4_state_e   dbg_state;

  hd44780_init_sequencer dut (
    .CLK_I     (clk),
    .RST_I     (rst_n),
    .tmr_start (tmr_start),
    .tmr_dat   (tmr_dat),
    .tmr_busy  (tmr_busy),
    .nyb_start (nyb_start),
    .nyb_dat   (nyb_dat),
    .nyb_rs    (nyb_rs),
    .nyb_busy  (nyb_busy),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .dbg_step  (dbg_step)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- peer models ----------------
  int tmr_cnt, nyb_cnt;
  int nyb_extra;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         tmr_cnt <= 0;
    else if (tmr_start) tmr_cnt <= int'(tmr_dat);
    else if (tmr_cnt != 0) tmr_cnt <= tmr_cnt - 1;
  end
  assign tmr_busy = (tmr_cnt != 0);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         nyb_cnt <= 0;
    else if (nyb_start) nyb_cnt <= int'($urandom_range(1, 4)) + nyb_extra;
    else if (nyb_cnt != 0) nyb_cnt <= nyb_cnt - 1;
  end
  assign nyb_busy = (nyb_cnt != 0);

  // ---------------- scoreboard ----------------
  logic [16:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Expected strobe order: {is_timer, value}.
  task automatic build_exp();
    exp_q.delete();
    exp_q.push_back({1'b1, PWR_EXP});
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back({1'b0, 12'h000, scr_data[i][7:4]});
      if (scr_byte[i]) exp_q.push_back({1'b0, 12'h000, scr_data[i][3:0]});
      exp_q.push_back({1'b1, scr_dly[i]});
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_tmr_start, prev_nyb_start, prev_tmr_busy, prev_nyb_busy, prev_done;
  logic        fall_valid, fall_src_tmr;
  int          fall_cyc, ev_cnt;
  logic [16:0] mon_exp, mon_got;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tmr_start = 1'b0; prev_nyb_start = 1'b0;
      prev_tmr_busy  = 1'b0; prev_nyb_busy  = 1'b0;
      prev_done = 1'b0; fall_valid = 1'b0; fall_src_tmr = 1'b0;
      fall_cyc = 0; ev_cnt = 0;
    end else begin
      if (prev_tmr_busy && !tmr_busy) begin
        fall_valid = 1'b1; fall_src_tmr = 1'b1; fall_cyc = cyc;
      end
      if (prev_nyb_busy && !nyb_busy) begin
        fall_valid = 1'b1; fall_src_tmr = 1'b0; fall_cyc = cyc;
      end
      if (tmr_start || nyb_start) begin
        check_eq("no_overlap", 32'(tmr_start && nyb_start), 0);
        mon_got = tmr_start ? {1'b1, tmr_dat} : {1'b0, 12'h000, nyb_dat};
        if (exp_q.size() == 0) begin
          check_eq("unexpected_strobe", {15'h0, mon_got}, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check_eq($sformatf("event%0d", ev_cnt), {15'h0, mon_got}, {15'h0, mon_exp});
        end
        check_eq("strobe_width", 32'(tmr_start ? prev_tmr_start : prev_nyb_start), 0);
        check_eq("peer_idle_at_strobe", 32'(tmr_start ? tmr_busy : nyb_busy), 0);
        check_eq("nyb_rs", 32'(nyb_rs), 0);
        check_eq("busy_while_running", 32'(busy), 1);
        check_eq("done_while_running", 32'(done), 0);
        if (fall_valid)
          check_eq("strobe_gap", cyc - fall_cyc, fall_src_tmr ? 3 : 2);
        fall_valid = 1'b0;
        ev_cnt++;
      end
      if (done && !prev_done) begin
        check_eq("done_gap", (fall_valid && fall_src_tmr) ? cyc - fall_cyc : 999, 1);
        check_eq("done_queue_empty", exp_q.size(), 0);
      end
      prev_tmr_start = tmr_start; prev_nyb_start = nyb_start;
      prev_tmr_busy  = tmr_busy;  prev_nyb_busy  = nyb_busy;
      prev_done      = done;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_reset(input string tag);
    check_eq({tag, "_tmr_start"}, 32'(tmr_start), 0);
    check_eq({tag, "_nyb_start"}, 32'(nyb_start), 0);
    check_eq({tag, "_tmr_dat"},   32'(tmr_dat), 0);
    check_eq({tag, "_nyb_dat"},   32'(nyb_dat), 0);
    check_eq({tag, "_nyb_rs"},    32'(nyb_rs), 0);
    check_eq({tag, "_busy"},      32'(busy), 1);
    check_eq({tag, "_done"},      32'(done), 0);
    check_eq({tag, "_step"},      32'(dbg_step), 0);
    check_eq({tag, "_state"},     32'(dbg_state), 32'(ST_PWR));
  endtask

  task automatic assert_reset(input string tag);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset(tag);
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    build_exp();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_done_seen"},   32'(done), 1);
    check_eq({tag, "_exp_drained"}, exp_q.size(), 0);
    check_eq({tag, "_busy_low"},    32'(busy), 0);
    check_eq({tag, "_final_step"},  32'(dbg_step), 8);
    repeat (12) @(negedge clk);
    check_eq({tag, "_done_sticky"}, 32'(done), 1);
    check_eq({tag, "_busy_sticky"}, 32'(busy), 0);
    check_eq({tag, "_state_done"},  32'(dbg_state), 32'(ST_DONE));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    rst_n     = 1'b0;
    nyb_extra = 0;
    repeat (3) @(posedge clk);
    #1 check_reset("por");

    // Full script with random nybble-sender latency.
    release_reset();
    wait_done("run1");

    // Reset while waiting on step 5's delay, then a full restart.
    assert_reset("rst_pre2");
    release_reset();
    n = 0;
    while (ev_cnt < 15 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq("reach_step5_wait", ev_cnt, 15);
    check_eq("step5_index", 32'(dbg_step), 5);
    repeat (3) @(negedge clk);
    assert_reset("rst_mid");
    release_reset();
    wait_done("run2");

    // Slow nybble sender: busy held 20 extra cycles per transfer.
    assert_reset("rst_pre3");
    nyb_extra = 20;
    release_reset();
    wait_done("run3_slow");

    // Random extra latency per run.
    for (int r = 0; r < 3; r++) begin
      assert_reset($sformatf("rst_rand%0d", r));
      nyb_extra = int'($urandom_range(0, 6));
      release_reset();
      wait_done($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
